// File: rtl/spi_slave_responder.sv
// SPI responder: oversampled SCLK/CS/MOSI, one-entry TX holding register, per-word RX handshake.
// Optional sticky TX underrun flag enabled by defining SPI_SLAVE_UNDERRUN_EN.
module spi_slave_responder #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_WORD   = 8'hFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic [7:0]        byte_cnt_o,
    output logic              tx_underrun_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, cs_hist_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [DATA_W-1:0] tx_shift_q, rx_shift_q, rx_data_q, hold_q;
    logic              hold_full_q, miso_q, rx_valid_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [7:0]        byte_cnt_q;
    logic              tx_write, is_load;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    // A coincident rise is treated as a glitch; the fall wins.
    assign sclk_rise = sclk_s & ~sclk_hist_q & ~sclk_fall;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;

    assign tx_write = tx_valid_i & ~hold_full_q;
    assign is_load  = (state_q == StLoad);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cs_fall) state_d = StLoad;
            StLoad:  state_d = cs_rise ? StIdle : StShift;
            StShift: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else if (sclk_fall && bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = cs_rise ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != StIdle);
        miso_oe_o  = busy_o;
        miso_o     = busy_o & miso_q;
        tx_ready_o = ~hold_full_q;
        rx_data_o  = rx_data_q;
        rx_valid_o = rx_valid_q;
        byte_cnt_o = byte_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
        end else begin
            rx_valid_q <= (state_q == StDone);
            // LOAD sees the pre-write holding state; a same-cycle write is kept for the next word.
            if (tx_write) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end else if (is_load) begin
                hold_full_q <= 1'b0;
            end
            case (state_q)
                StIdle: if (cs_fall) byte_cnt_q <= '0;
                StLoad: begin
                    tx_shift_q <= hold_full_q ? hold_q : FILL_WORD;
                    bit_cnt_q  <= '0;
                end
                StShift: begin
                    if (sclk_fall) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                    end else if (sclk_rise) begin
                        miso_q     <= tx_shift_q[DATA_W-1];
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                StDone: begin
                    rx_data_q <= rx_shift_q;
                    if (byte_cnt_q != 8'hFF) byte_cnt_q <= byte_cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            underrun_q <= 1'b0;
        end else if (is_load && !hold_full_q) begin
            underrun_q <= 1'b1;
        end else if (tx_write && state_q == StIdle) begin
            underrun_q <= 1'b0;
        end
    end

    assign tx_underrun_o = underrun_q;
`else
    assign tx_underrun_o = 1'b0;
`endif

endmodule
